bicintp_seq: RTL
================

# bicintp_seq

Sequencer for the bicubic-interpolation datapath (`bicintp_cal`). Per output pixel it issues four contiguous tap reads to the source line buffer and drives `intp_enb` with the matching fractional weights. It walks the destination frame in 11.8 fixed-point source coordinates and applies back-pressure and in-flight credit control. It sits between the line-buffer RAM, the weight LUT, `bicintp_cal` and the output pingpong buffer.

## Interface
- `AW`, 11, source/destination coordinate width.
- `MAX_INFLIGHT`, 8, maximum number of pixel groups issued whose `pix_vld` has not yet returned.
- `sys_clk`  in  1  system clock (125/105 MHz).
- `sys_rstn`  in  1  reset, **asynchronous, active-low**.
- `start`  in  1  one-cycle frame start; ignored unless in IDLE.
- `cfg_src_w`  in  AW  source width in pixels; sampled on `start`.
- `cfg_dst_w`, `cfg_dst_h`  in  AW  destination size; sampled on `start`. Both must be ≥1.
- `cfg_step_x`, `cfg_step_y`  in  16  source step per destination pixel or row, 8.8 format; sampled on `start`.
- `line_req`  out  1  request for the four source rows around `line_y`.
- `line_y`  out  AW  integer source row (base row).
- `line_rdy`  in  1  line buffer holds rows `line_y-1..line_y+2`.
- `line_adv`  out  1  one-cycle pulse; destination row finished.
- `ram_rd_en`  out  1  line-buffer column read. Read data is valid one cycle later.
- `ram_rd_addr`  out  AW  column address.
- `intp_enb`  out  1  to `bicintp_cal`; tap valid.
- `intp_fx`, `intp_fy`  out  8  fractional x and y for the weight LUT, aligned with `intp_enb`.
- `intp_tap`  out  2  tap index 0..3, aligned with `intp_enb`.
- `pix_vld`  in  1  `cmos_bicintp_data_vld` returned from the datapath.
- `fifo_afull`  in  1  output buffer almost full.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle end-of-frame pulse.

## Operation
- Reset value of every output is 0. Internal accumulators, counters and state reset to 0 / IDLE.
- States:
  - IDLE → WAIT_LINE on `start`. Latches the cfg inputs and clears `x_acc`, `y_acc`, `col`, `row`.
  - WAIT_LINE:
    - `line_req`=1, `line_y`=`y_acc[18:8]`.
    - → ISSUE when `line_rdy`=1, `fifo_afull`=0 and `inflight`<`MAX_INFLIGHT`.
  - ISSUE: four cycles, tap k=0..3. `ram_rd_addr` is the tap address for `base=x_acc[18:8]`. After tap 3:
    - `x_acc += step_x`, `col++`.
    - If `col` was `dst_w-1` → ROW_END.
    - Else if the issue condition holds → next group starts back-to-back.
    - Else → HOLD.
  - HOLD: → ISSUE when `fifo_afull`=0 and `inflight`<`MAX_INFLIGHT`.
  - ROW_END: one cycle.
    - `line_adv`=1, `y_acc += step_y`, `x_acc`=0, `col`=0, `row++`.
    - → DRAIN if `row` was `dst_h-1`, else → WAIT_LINE.
  - DRAIN: wait for `inflight`==0 → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- A group of four taps is never split. Back-pressure is checked only at group boundaries.
- Tap address: `a = base + k - 1`, computed as (AW+1)-bit signed. With clamping, `a<0` → 0 and `a>src_w-1` → `src_w-1`.
- `x_acc` and `y_acc` are AW+8 bits, unsigned. Overflow wraps silently; configuration is responsible for avoiding it.
- `inflight` increments when tap 0 issues and decrements on `pix_vld`. If both happen in the same cycle, the count is unchanged.
- `start` received while busy is ignored. Asynchronous reset mid-frame returns the block to IDLE immediately with all outputs at 0.

## Timing
- `intp_enb`, `intp_fx`, `intp_fy` and `intp_tap` are registered one cycle after the `ram_rd_en` for the same tap, so they align with the RAM data at `bicintp_cal` p0..p3.
- `intp_fx`=`x_acc[7:0]` and `intp_fy`=`y_acc[7:0]`, captured at tap 0 and held for the group.
- Sustained throughput is one pixel per four cycles. `intp_enb` stays continuously high across back-to-back groups.
- The first `ram_rd_en` occurs two cycles after `start` when `line_rdy` is already 1.

## Configuration
- `BICINTP_EDGE_CLAMP_EN`:
  - Defined: tap addresses are clamped to `[0, src_w-1]`.
  - Undefined: `a` is truncated to AW bits (wraps modulo 2^AW). This is cheaper, and border pixels are invalid.

## Structure
- `bicintp_pkg` holds:
  - the state enum (IDLE, WAIT_LINE, ISSUE, HOLD, ROW_END, DRAIN, DONE);
  - `FRAC_W`=8 and `TAPS`=4;
  - the 8.8 step type.
- One sub-module, `bicintp_tap_addr`: combinational base+k−1 computation plus the optional clamp.

## Test plan
- Scaling 1:1:
  - Stimulus: `src_w`=`dst_w`=4, `dst_h`=1, step 0x0100, `line_rdy`=1.
  - Response: addresses 0,0,1,2 | 0,1,2,3 | 1,2,3,3 | 2,3,3,3 (clamped), `intp_fx`=0, one `line_adv`, then `done` once 3 more `pix_vld` have returned.
- 2× upscale:
  - Stimulus: step_x 0x0080, `dst_w`=4.
  - Response: `intp_fx` sequence 0x00,0x80,0x00,0x80, and base sequence 0,0,1,1.
- Back-pressure:
  - Stimulus: raise `fifo_afull` during tap 1.
  - Response: taps 2 and 3 still issue, then HOLD, with no `ram_rd_en` until `fifo_afull` drops.
- Credit:
  - Stimulus: `MAX_INFLIGHT`=2 and `pix_vld` held low.
  - Response: exactly 8 `intp_enb` cycles, then stall. A single `pix_vld` releases exactly one more group.
  - Also: `pix_vld` coincident with tap 0 leaves `inflight` unchanged.
- Line handshake / reset:
  - Stimulus: `line_rdy` low for 10 cycles after ROW_END.
  - Response: no reads during the wait. `line_y` equals the `y_acc` integer part.
  - Stimulus: assert `sys_rstn` low mid-ISSUE.
  - Response: all outputs 0 the same cycle, and a fresh `start` runs a full frame.
- Without `BICINTP_EDGE_CLAMP_EN`:
  - Stimulus: base 0.
  - Response: tap 0 address 0x7FF.

Source files
------------

// File: rtl/bicintp_pkg.sv
// bicintp_pkg: shared types and constants for the bicubic-interpolation
// sequencer (bicintp_seq) and its tap-address helper.
package bicintp_pkg;

   localparam int FRAC_W = 8;   // fractional bits of the 11.8 / 8.8 coordinates
   localparam int TAPS   = 4;   // column taps per output pixel

   // Source step per destination pixel/row, 8.8 unsigned fixed point.
   typedef logic [15:0] step_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LINE = 3'd1,
      ISSUE     = 3'd2,
      HOLD      = 3'd3,
      ROW_END   = 3'd4,
      DRAIN     = 3'd5,
      DONE      = 3'd6
   } state_t;

endpackage

// File: rtl/bicintp_seq_if.sv
// bicintp_seq_if: frame control, line-buffer, RAM, datapath and credit
// signals of the bicubic sequencer, bundled with master (sequencer) and
// slave (environment) modports. dbg_state exposes the sequencer FSM.
//
// Handshakes: line_req/line_rdy is level based -- the sequencer holds
// line_req high in WAIT_LINE and moves on only in a cycle where line_rdy is
// sampled high at the clock edge. ram_rd_en and intp_enb are fire-and-forget
// strobes with no ready; flow control comes solely from fifo_afull and the
// pix_vld credit return, both evaluated only at pixel-group boundaries.
interface bicintp_seq_if #(parameter int AW = 11);
   import bicintp_pkg::*;

   logic          start;
   logic [AW-1:0] cfg_src_w;
   logic [AW-1:0] cfg_dst_w;
   logic [AW-1:0] cfg_dst_h;
   step_t         cfg_step_x;
   step_t         cfg_step_y;
   logic          line_req;
   logic [AW-1:0] line_y;
   logic          line_rdy;
   logic          line_adv;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic          intp_enb;
   logic [7:0]    intp_fx;
   logic [7:0]    intp_fy;
   logic [1:0]    intp_tap;
   logic          pix_vld;
   logic          fifo_afull;
   logic          busy;
   logic          done;
   state_t        dbg_state;

   modport master (
      input  start, cfg_src_w, cfg_dst_w, cfg_dst_h, cfg_step_x, cfg_step_y,
      input  line_rdy, pix_vld, fifo_afull,
      output line_req, line_y, line_adv, ram_rd_en, ram_rd_addr,
      output intp_enb, intp_fx, intp_fy, intp_tap, busy, done, dbg_state
   );

   modport slave (
      output start, cfg_src_w, cfg_dst_w, cfg_dst_h, cfg_step_x, cfg_step_y,
      output line_rdy, pix_vld, fifo_afull,
      input  line_req, line_y, line_adv, ram_rd_en, ram_rd_addr,
      input  intp_enb, intp_fx, intp_fy, intp_tap, busy, done, dbg_state
   );

endinterface

// File: rtl/bicintp_tap_addr.sv
// bicintp_tap_addr: column address of tap k around base column, a = base+k-1.
// Build option BICINTP_EDGE_CLAMP_EN: when defined the address is clamped to
// [0, src_w-1]; otherwise it wraps modulo 2^AW (border pixels are garbage).
module bicintp_tap_addr #(
   parameter int AW = 11
) (
   input  logic [AW-1:0] base,
   input  logic [1:0]    tap,
   input  logic [AW-1:0] src_w,
   output logic [AW-1:0] addr
);

`ifdef BICINTP_EDGE_CLAMP_EN
   // Two guard bits: the top bit flags base+k-1 < 0, the next catches sums past 2^AW-1.
   logic [AW+1:0] sum;
   logic [AW-1:0] last_col;

   // Signed tap address, then clamp both ends to the source line.
   always_comb begin
      sum      = {2'b00, base} + {{AW{1'b0}}, tap} - (AW+2)'(1);
      last_col = src_w - AW'(1);
      if (sum[AW+1])
         addr = '0;
      else if (sum[AW:0] > {1'b0, last_col})
         addr = last_col;
      else
         addr = sum[AW-1:0];
   end
`else
   logic unused_src_w;

   assign unused_src_w = ^src_w;
   // Plain modulo-2^AW address; tap 0 at base 0 wraps to the all-ones column.
   assign addr = base + {{(AW-2){1'b0}}, tap} - AW'(1);
`endif

endmodule

// File: rtl/bicintp_seq.sv
// bicintp_seq: walks the destination frame in 11.8 source coordinates and, per
// output pixel, issues four contiguous line-buffer column reads plus the
// matching intp_* strobes (one cycle later, aligned with RAM data).
// Flow control: line_rdy per row, fifo_afull and an in-flight pixel credit
// counter checked only between four-tap groups.
// Build option BICINTP_EDGE_CLAMP_EN selects clamped edge addresses.
module bicintp_seq
   import bicintp_pkg::*;
#(
   parameter int AW           = 11,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic         sys_clk,
   input  logic         sys_rstn,
   bicintp_seq_if.master bus
);

   localparam int ACC_W = AW + FRAC_W;
   localparam int CW    = $clog2(MAX_INFLIGHT + 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    src_w_q, dst_w_q, dst_h_q;
   step_t            step_x_q, step_y_q;
   logic [ACC_W-1:0] x_acc_q, y_acc_q;
   logic [AW-1:0]    col_q, row_q;
   logic [1:0]       tap_q;
   logic [CW-1:0]    inflight_q;
   logic [AW-1:0]    tap_addr;
   logic             issue_ok, last_tap, last_col, last_row;
   logic             tap0_fire, credit_ret;

   assign issue_ok   = !bus.fifo_afull && (inflight_q < CW'(MAX_INFLIGHT));
   assign last_tap   = (tap_q == 2'(TAPS - 1));
   assign last_col   = (col_q == dst_w_q - AW'(1));
   assign last_row   = (row_q == dst_h_q - AW'(1));
   assign tap0_fire  = (state_q == ISSUE) && (tap_q == 2'd0);
   assign credit_ret = bus.pix_vld && (inflight_q != '0);

   bicintp_tap_addr #(.AW(AW)) u_tap_addr (
      .base  (x_acc_q[ACC_W-1:FRAC_W]),
      .tap   (tap_q),
      .src_w (src_w_q),
      .addr  (tap_addr)
   );

   // FSM state register.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // FSM next state; a four-tap group always runs to completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (bus.start) state_d = WAIT_LINE;
         WAIT_LINE: if (bus.line_rdy && issue_ok) state_d = ISSUE;
         ISSUE: begin
            if (last_tap) begin
               if (last_col)      state_d = ROW_END;
               else if (issue_ok) state_d = ISSUE;
               else               state_d = HOLD;
            end
         end
         HOLD:      if (issue_ok) state_d = ISSUE;
         ROW_END:   state_d = last_row ? DRAIN : WAIT_LINE;
         DRAIN:     if (inflight_q == '0) state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // FSM outputs; every one decodes registered state only.
   always_comb begin
      bus.line_req    = (state_q == WAIT_LINE);
      bus.line_y      = y_acc_q[ACC_W-1:FRAC_W];
      bus.line_adv    = (state_q == ROW_END);
      bus.ram_rd_en   = (state_q == ISSUE);
      bus.ram_rd_addr = (state_q == ISSUE) ? tap_addr : '0;
      bus.busy        = (state_q != IDLE);
      bus.done        = (state_q == DONE);
      bus.dbg_state   = state_q;
   end

   // Configuration latch, coordinate accumulators and position counters.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         src_w_q  <= '0;
         dst_w_q  <= '0;
         dst_h_q  <= '0;
         step_x_q <= '0;
         step_y_q <= '0;
         x_acc_q  <= '0;
         y_acc_q  <= '0;
         col_q    <= '0;
         row_q    <= '0;
         tap_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  src_w_q  <= bus.cfg_src_w;
                  dst_w_q  <= bus.cfg_dst_w;
                  dst_h_q  <= bus.cfg_dst_h;
                  step_x_q <= bus.cfg_step_x;
                  step_y_q <= bus.cfg_step_y;
                  x_acc_q  <= '0;
                  y_acc_q  <= '0;
                  col_q    <= '0;
                  row_q    <= '0;
                  tap_q    <= '0;
               end
            end
            ISSUE: begin
               // tap_q wraps 3 -> 0, so a following group starts at tap 0.
               tap_q <= tap_q + 2'd1;
               if (last_tap) begin
                  x_acc_q <= x_acc_q + ACC_W'(step_x_q);
                  col_q   <= col_q + AW'(1);
               end
            end
            ROW_END: begin
               y_acc_q <= y_acc_q + ACC_W'(step_y_q);
               x_acc_q <= '0;
               col_q   <= '0;
               row_q   <= row_q + AW'(1);
            end
            default: ;
         endcase
      end
   end

   // Pixel credits: +1 on tap 0, -1 on pix_vld, unchanged when both coincide.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn)
         inflight_q <= '0;
      else if (tap0_fire && !credit_ret)
         inflight_q <= inflight_q + CW'(1);
      else if (!tap0_fire && credit_ret)
         inflight_q <= inflight_q - CW'(1);
   end

   // Datapath strobes, one cycle behind ram_rd_en to line up with RAM data.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         bus.intp_enb <= 1'b0;
         bus.intp_tap <= '0;
         bus.intp_fx  <= '0;
         bus.intp_fy  <= '0;
      end else begin
         bus.intp_enb <= (state_q == ISSUE);
         bus.intp_tap <= (state_q == ISSUE) ? tap_q : 2'd0;
         if (tap0_fire) begin
            bus.intp_fx <= x_acc_q[FRAC_W-1:0];
            bus.intp_fy <= y_acc_q[FRAC_W-1:0];
         end
      end
   end

endmodule
